// File: rtl/fx_measure_regs.sv
// ---------------------------------------------------------------------------
// fx_measure_regs
//
// fx-bus responder register block in front of the ultrasonic measurement
// engine (alg_box). The UART host uses it, through commu_top, to start
// measurements, run periodic auto-fire, collect results through a snapshot
// scheme, and read status flags and counters. Everything runs in clk_sys.
//
// Register map (offset from BASE_ADDR):
//   0x0 ID       RO  DEV_ID
//   0x1 CTRL     RW  [0] FIRE (write-1 pulse, reads 0), [1] AUTO_EN,
//                    [2] CNT_CLR (write-1 pulse, reads 0)
//   0x2 STATUS   RO  [0] BUSY, [1] DONE, [2] ERR, [3] TIMEOUT
//                    (DONE/ERR/TIMEOUT are sticky and clear when read)
//   0x3 DATA0    RO  result[7:0]; reading it snapshots result[23:8]
//   0x4 DATA1    RO  snapshot of result[15:8]
//   0x5 DATA2    RO  snapshot of result[23:16]
//   0x6 MCNT     RO  successful measurements, wraps
//   0x7 ECNT     RO  errors + timeouts, saturates at 255
//   0x8 AUTO_PER RW  auto-fire period in ms, 0 disables auto-fire
//
// Ports:
//   clk_sys, rst_n         clock, asynchronous active-low reset
//   pluse_us               one-cycle strobe every microsecond
//   fx_waddr/fx_wr/fx_data write cycle from the fx-bus initiator
//   fx_raddr/fx_rd/fx_q    read cycle; fx_q is registered and holds
//   fire_measure           one-cycle start pulse to alg_box
//   done_measure/err_measure/data_measure  completion/error from alg_box
// ---------------------------------------------------------------------------
module fx_measure_regs #(
  parameter logic [15:0] BASE_ADDR  = 16'h0100,
  parameter logic [7:0]  DEV_ID     = 8'h5A,
  parameter int unsigned TIMEOUT_US = 60000,
  parameter int unsigned DW         = 24
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          pluse_us,
  input  logic [15:0]   fx_waddr,
  input  logic          fx_wr,
  input  logic [7:0]    fx_data,
  input  logic [15:0]   fx_raddr,
  input  logic          fx_rd,
  output logic [7:0]    fx_q,
  output logic          fire_measure,
  input  logic          done_measure,
  input  logic          err_measure,
  input  logic [DW-1:0] data_measure
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [3:0] OFF_ID       = 4'h0;
  localparam logic [3:0] OFF_CTRL     = 4'h1;
  localparam logic [3:0] OFF_STATUS   = 4'h2;
  localparam logic [3:0] OFF_DATA0    = 4'h3;
  localparam logic [3:0] OFF_DATA1    = 4'h4;
  localparam logic [3:0] OFF_DATA2    = 4'h5;
  localparam logic [3:0] OFF_MCNT     = 4'h6;
  localparam logic [3:0] OFF_ECNT     = 4'h7;
  localparam logic [3:0] OFF_AUTO_PER = 4'h8;

  // Timeout counter only needs to reach TIMEOUT_US-1; the expiry is
  // detected on the tick that would take it to TIMEOUT_US.
  localparam int unsigned    TW       = (TIMEOUT_US > 1) ? $clog2(TIMEOUT_US) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_US - 1);
  localparam logic [9:0]     US_LAST  = 10'd999;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e        state_q,     state_d;
  logic          fire_q,      fire_d;
  logic          auto_en_q,   auto_en_d;
  logic [7:0]    auto_per_q,  auto_per_d;
  logic          done_flag_q, done_flag_d;
  logic          err_flag_q,  err_flag_d;
  logic          tmo_flag_q,  tmo_flag_d;
  logic [23:0]   result_q,    result_d;
  logic [15:0]   shadow_q,    shadow_d;
  logic [7:0]    mcnt_q,      mcnt_d;
  logic [7:0]    ecnt_q,      ecnt_d;
  logic [TW-1:0] tmo_cnt_q,   tmo_cnt_d;
  logic [9:0]    us_cnt_q,    us_cnt_d;
  logic [7:0]    ms_cnt_q,    ms_cnt_d;
  logic [7:0]    rd_data_q,   rd_data_d;

  assign fx_q         = rd_data_q;
  assign fire_measure = fire_q;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic       wr_hit, rd_hit;
  logic [3:0] wr_off, rd_off;

  assign wr_hit = fx_wr && (fx_waddr[15:4] == BASE_ADDR[15:4]);
  assign rd_hit = fx_rd && (fx_raddr[15:4] == BASE_ADDR[15:4]);
  assign wr_off = fx_waddr[3:0];
  assign rd_off = fx_raddr[3:0];

  logic ctrl_wr, per_wr, fire_wr, cnt_clr;

  assign ctrl_wr = wr_hit && (wr_off == OFF_CTRL);
  assign per_wr  = wr_hit && (wr_off == OFF_AUTO_PER);
  assign fire_wr = ctrl_wr && fx_data[0];
  assign cnt_clr = ctrl_wr && fx_data[2];

  // Result is always presented as 24 bits to the register map.
  logic [23:0] data_ext;
  assign data_ext = 24'(data_measure);

  // -------------------------------------------------------------------------
  // Measurement events, only meaningful while waiting on alg_box
  // -------------------------------------------------------------------------
  logic in_wait, ev_done, ev_err, ev_tmo;

  assign in_wait = (state_q == WAIT);
  assign ev_done = in_wait && done_measure;
  assign ev_err  = in_wait && err_measure;
  assign ev_tmo  = in_wait && pluse_us && (tmo_cnt_q == TMO_LAST);

  // -------------------------------------------------------------------------
  // Auto-fire timebase: microseconds -> milliseconds -> period tick
  // -------------------------------------------------------------------------
  logic ms_tick, auto_tick, start_req;

  assign ms_tick   = auto_en_q && pluse_us && (us_cnt_q == US_LAST);
  assign auto_tick = ms_tick && (auto_per_q != 8'd0) &&
                     (ms_cnt_q == auto_per_q - 8'd1);
  assign start_req = fire_wr || auto_tick;

  // -------------------------------------------------------------------------
  // Read mux (pre-edge values, so a same-cycle write or event is not seen)
  // -------------------------------------------------------------------------
  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    unique case (rd_off)
      OFF_ID:       rd_mux = DEV_ID;
      OFF_CTRL:     rd_mux = {6'b0, auto_en_q, 1'b0};
      OFF_STATUS:   rd_mux = {4'b0, tmo_flag_q, err_flag_q, done_flag_q, in_wait};
      OFF_DATA0:    rd_mux = result_q[7:0];
      OFF_DATA1:    rd_mux = shadow_q[7:0];
      OFF_DATA2:    rd_mux = shadow_q[15:8];
      OFF_MCNT:     rd_mux = mcnt_q;
      OFF_ECNT:     rd_mux = ecnt_q;
      OFF_AUTO_PER: rd_mux = auto_per_q;
      default:      rd_mux = 8'h00;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it
    // unassigned; without this the tool infers latches.
    state_d     = state_q;
    fire_d      = 1'b0;
    auto_en_d   = auto_en_q;
    auto_per_d  = auto_per_q;
    done_flag_d = done_flag_q;
    err_flag_d  = err_flag_q;
    tmo_flag_d  = tmo_flag_q;
    result_d    = result_q;
    shadow_d    = shadow_q;
    mcnt_d      = mcnt_q;
    ecnt_d      = ecnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    us_cnt_d    = us_cnt_q;
    ms_cnt_d    = ms_cnt_q;
    rd_data_d   = rd_data_q;

    // Host writes
    if (ctrl_wr) auto_en_d  = fx_data[1];
    if (per_wr)  auto_per_d = fx_data;

    // Auto timer; idles at zero while auto-fire is disabled.
    if (!auto_en_q) begin
      us_cnt_d = '0;
      ms_cnt_d = '0;
    end else begin
      if (pluse_us) us_cnt_d = (us_cnt_q == US_LAST) ? 10'd0 : us_cnt_q + 10'd1;
      if (ms_tick && (auto_per_q != 8'd0))
        ms_cnt_d = auto_tick ? 8'd0 : ms_cnt_q + 8'd1;
    end
    if (per_wr) ms_cnt_d = '0;

    // Host reads and their side effects
    if (fx_rd) rd_data_d = rd_hit ? rd_mux : 8'h00;
    if (rd_hit && (rd_off == OFF_STATUS)) begin
      done_flag_d = 1'b0;
      err_flag_d  = 1'b0;
      tmo_flag_d  = 1'b0;
    end
    if (rd_hit && (rd_off == OFF_DATA0)) shadow_d = result_q[23:8];

    // Measurement FSM; start requests while waiting are simply dropped.
    unique case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (start_req) begin
          state_d = WAIT;
          fire_d  = 1'b1;
        end
      end
      WAIT: begin
        if (pluse_us) tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (ev_done || ev_err || ev_tmo) begin
          state_d   = IDLE;
          tmo_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outcome bookkeeping. Done takes priority: a simultaneous error still
    // raises ERR but is not counted. Sticky sets override a same-cycle clear.
    if (ev_done) begin
      result_d    = data_ext;
      done_flag_d = 1'b1;
      mcnt_d      = mcnt_q + 8'd1;
    end
    if (ev_err) err_flag_d = 1'b1;
    if (ev_tmo && !ev_done && !ev_err) tmo_flag_d = 1'b1;
    if (!ev_done && (ev_err || ev_tmo) && (ecnt_q != 8'hFF))
      ecnt_d = ecnt_q + 8'd1;

    if (cnt_clr) begin
      mcnt_d = '0;
      ecnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge rst_n) begin
    // NOTE: non-blocking assignments only, so every flop samples the
    // pre-edge value of every other flop regardless of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      fire_q      <= 1'b0;
      auto_en_q   <= 1'b0;
      auto_per_q  <= '0;
      done_flag_q <= 1'b0;
      err_flag_q  <= 1'b0;
      tmo_flag_q  <= 1'b0;
      result_q    <= '0;
      shadow_q    <= '0;
      mcnt_q      <= '0;
      ecnt_q      <= '0;
      tmo_cnt_q   <= '0;
      us_cnt_q    <= '0;
      ms_cnt_q    <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      fire_q      <= fire_d;
      auto_en_q   <= auto_en_d;
      auto_per_q  <= auto_per_d;
      done_flag_q <= done_flag_d;
      err_flag_q  <= err_flag_d;
      tmo_flag_q  <= tmo_flag_d;
      result_q    <= result_d;
      shadow_q    <= shadow_d;
      mcnt_q      <= mcnt_d;
      ecnt_q      <= ecnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      us_cnt_q    <= us_cnt_d;
      ms_cnt_q    <= ms_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_fx_measure_regs.sv
// ---------------------------------------------------------------------------
// tb_fx_measure_regs
//
// Directed bench for fx_measure_regs. pluse_us is held high so one clock is
// one microsecond; TIMEOUT_US is shortened to keep the run short.
// ---------------------------------------------------------------------------
module tb_fx_measure_regs;

  localparam int unsigned TMO = 200;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        pluse_us;
  logic [15:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic [15:0] fx_raddr;
  logic        fx_rd;
  logic [7:0]  fx_q;
  logic        fire_measure;
  logic        done_measure;
  logic        err_measure;
  logic [23:0] data_measure;

  int n_checks = 0;
  int n_errors = 0;
  int fire_cnt = 0;
  int cyc      = 0;

  fx_measure_regs #(
    .BASE_ADDR (16'h0100),
    .DEV_ID    (8'h5A),
    .TIMEOUT_US(TMO),
    .DW        (24)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .pluse_us    (pluse_us),
    .fx_waddr    (fx_waddr),
    .fx_wr       (fx_wr),
    .fx_data     (fx_data),
    .fx_raddr    (fx_raddr),
    .fx_rd       (fx_rd),
    .fx_q        (fx_q),
    .fire_measure(fire_measure),
    .done_measure(done_measure),
    .err_measure (err_measure),
    .data_measure(data_measure)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys) if (fire_measure === 1'b1) fire_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fx_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    fx_waddr = a; fx_data = d; fx_wr = 1'b1;
    @(negedge clk_sys);
    fx_wr = 1'b0;
  endtask

  task automatic fx_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk_sys);
    fx_raddr = a; fx_rd = 1'b1;
    @(negedge clk_sys);
    fx_rd = 1'b0;
    d = fx_q;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    fx_read(a, d);
    check(tag, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic pulse(input logic dn, input logic er, input logic [23:0] d);
    @(negedge clk_sys);
    done_measure = dn; err_measure = er; data_measure = d;
    @(negedge clk_sys);
    done_measure = 1'b0; err_measure = 1'b0;
  endtask

  task automatic wait_fire(input string tag, output int at);
    bit seen = 1'b0;
    at = 0;
    for (int i = 0; i < 2500 && !seen; i++) begin
      @(negedge clk_sys);
      if (fire_measure === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check(tag, {31'h0, seen}, 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  initial begin
    int base, t1, t2, t3;
    logic [7:0] d;

    rst_n = 1'b0; pluse_us = 1'b1;
    fx_waddr = '0; fx_wr = 1'b0; fx_data = '0;
    fx_raddr = '0; fx_rd = 1'b0;
    done_measure = 1'b0; err_measure = 1'b0; data_measure = '0;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;

    // Reset state and basic decode
    check("reset_fx_q", {24'h0, fx_q}, 32'h0);
    check("reset_fire", {31'h0, fire_measure}, 32'h0);
    rd_chk("id", 16'h0100, 8'h5A);
    rd_chk("status_reset", 16'h0102, 8'h00);
    rd_chk("mcnt_reset", 16'h0106, 8'h00);
    rd_chk("miss_read", 16'h0200, 8'h00);

    // Single manual measurement
    base = fire_cnt;
    fx_write(16'h0101, 8'h01);
    rd_chk("status_busy", 16'h0102, 8'h01);
    check("one_fire", fire_cnt - base, 1);
    pulse(1'b1, 1'b0, 24'hABCDEF);
    rd_chk("status_done", 16'h0102, 8'h02);
    rd_chk("status_cleared", 16'h0102, 8'h00);
    rd_chk("data0", 16'h0103, 8'hEF);
    rd_chk("data1", 16'h0104, 8'hCD);
    rd_chk("data2", 16'h0105, 8'hAB);
    rd_chk("mcnt_1", 16'h0106, 8'h01);

    // Snapshot holds until DATA0 is read again
    rd_chk("snap_data0", 16'h0103, 8'hEF);
    fx_write(16'h0101, 8'h01);
    pulse(1'b1, 1'b0, 24'h123456);
    rd_chk("snap_data1_old", 16'h0104, 8'hCD);
    rd_chk("snap_data2_old", 16'h0105, 8'hAB);
    rd_chk("snap_data0_new", 16'h0103, 8'h56);
    rd_chk("snap_data1_new", 16'h0104, 8'h34);
    rd_chk("snap_data2_new", 16'h0105, 8'h12);
    rd_chk("status_clr2", 16'h0102, 8'h02);

    // FIRE while busy is dropped; error; timeout
    base = fire_cnt;
    fx_write(16'h0101, 8'h01);
    fx_write(16'h0101, 8'h01);
    fx_write(16'h0101, 8'h01);
    check("busy_drop", fire_cnt - base, 1);
    pulse(1'b0, 1'b1, 24'h0);
    rd_chk("status_err", 16'h0102, 8'h04);
    rd_chk("ecnt_1", 16'h0107, 8'h01);
    fx_write(16'h0101, 8'h01);
    repeat (TMO - 15) @(negedge clk_sys);
    rd_chk("pre_timeout_busy", 16'h0102, 8'h01);
    repeat (20) @(negedge clk_sys);
    rd_chk("status_timeout", 16'h0102, 8'h08);
    rd_chk("ecnt_2", 16'h0107, 8'h02);

    // Auto-fire every 2 ms
    fx_write(16'h0108, 8'h02);
    fx_write(16'h0101, 8'h02);
    rd_chk("ctrl_readback", 16'h0101, 8'h02);
    wait_fire("auto_fire_1", t1);
    pulse(1'b1, 1'b0, 24'h000001);
    wait_fire("auto_fire_2", t2);
    pulse(1'b1, 1'b0, 24'h000002);
    wait_fire("auto_fire_3", t3);
    pulse(1'b1, 1'b0, 24'h000003);
    fx_write(16'h0101, 8'h00);
    check("auto_period_a", t2 - t1, 2000);
    check("auto_period_b", t3 - t2, 2000);
    rd_chk("mcnt_5", 16'h0106, 8'h05);

    // ECNT saturates
    for (int i = 0; i < 253; i++) begin
      fx_write(16'h0101, 8'h01);
      pulse(1'b0, 1'b1, 24'h0);
    end
    rd_chk("ecnt_255", 16'h0107, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      fx_write(16'h0101, 8'h01);
      pulse(1'b0, 1'b1, 24'h0);
    end
    rd_chk("ecnt_sat", 16'h0107, 8'hFF);

    // MCNT wraps
    for (int i = 0; i < 250; i++) begin
      fx_write(16'h0101, 8'h01);
      pulse(1'b1, 1'b0, 24'h0);
    end
    rd_chk("mcnt_255", 16'h0106, 8'hFF);
    fx_write(16'h0101, 8'h01);
    pulse(1'b1, 1'b0, 24'h0);
    rd_chk("mcnt_wrap", 16'h0106, 8'h00);
    fx_write(16'h0101, 8'h01);
    pulse(1'b1, 1'b0, 24'h0);
    rd_chk("mcnt_after_wrap", 16'h0106, 8'h01);
    fx_write(16'h0101, 8'h04);
    rd_chk("cnt_clr_m", 16'h0106, 8'h00);
    rd_chk("cnt_clr_e", 16'h0107, 8'h00);
    fx_read(16'h0102, d);

    // STATUS read in the same cycle as done: old value returned, set wins
    fx_write(16'h0101, 8'h01);
    @(negedge clk_sys);
    fx_raddr = 16'h0102; fx_rd = 1'b1; done_measure = 1'b1; data_measure = 24'h000042;
    @(negedge clk_sys);
    fx_rd = 1'b0; done_measure = 1'b0;
    check("set_wins_read", {24'h0, fx_q}, 32'h01);
    rd_chk("set_wins_after", 16'h0102, 8'h02);

    // Same-cycle done and err
    fx_write(16'h0101, 8'h01);
    pulse(1'b1, 1'b1, 24'h000077);
    rd_chk("done_err_status", 16'h0102, 8'h06);
    rd_chk("done_err_mcnt", 16'h0106, 8'h02);
    rd_chk("done_err_ecnt", 16'h0107, 8'h00);
    rd_chk("done_err_data", 16'h0103, 8'h77);

    // Reset in the middle of a measurement
    fx_write(16'h0108, 8'h05);
    fx_write(16'h0101, 8'h01);
    rd_chk("pre_reset_busy", 16'h0102, 8'h01);
    do_reset();
    check("rst_fx_q", {24'h0, fx_q}, 32'h0);
    check("rst_fire", {31'h0, fire_measure}, 32'h0);
    pulse(1'b1, 1'b0, 24'h999999);
    rd_chk("rst_status", 16'h0102, 8'h00);
    rd_chk("rst_mcnt", 16'h0106, 8'h00);
    rd_chk("rst_data0", 16'h0103, 8'h00);
    rd_chk("rst_auto_per", 16'h0108, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
